countdown_timer: RTL
====================

// Module: countdown_timer
//
// PURPOSE
//   BCD mm:ss countdown timer. It loads a preset time and decrements it once per
//   prescaled tick until 00:00, then flags expiry. It runs in the opposite
//   direction to the free-running 00..59 up-counter. Its digit outputs drive the
//   same seven-segment display path, and done/expired feed the alarm logic.
//
// PARAMETERS
//   TICK_DIV  100_000_000  clk cycles per decrement (>=1; 1 = decrement every clk)
//
// PORTS
//   clk       in   1  system clock, rising edge
//   reset     in   1  async reset, active-low
//   load      in   1  load preset digits (1-cycle strobe)
//   ld_m_l    in   3  preset minutes tens, 0..5
//   ld_m_r    in   4  preset minutes ones, 0..9
//   ld_s_l    in   3  preset seconds tens, 0..5
//   ld_s_r    in   4  preset seconds ones, 0..9
//   start     in   1  start/resume strobe
//   pause     in   1  pause strobe
//   M_L       out  3  minutes tens digit
//   M_R       out  4  minutes ones digit
//   Q_L       out  3  seconds tens digit
//   Q_R       out  4  seconds ones digit
//   running   out  1  high in RUN
//   done      out  1  1-cycle pulse on reaching 00:00
//   expired   out  1  level, high in EXPIRED
//   load_err  out  1  1-cycle pulse, invalid preset rejected
//
// BEHAVIOUR
//   Clock/reset: one clock; reset is asynchronous and active-low.
//   Reset (reset==0): all digits 0, state IDLE, prescaler 0, every output 0.
//   All outputs are registered and change only on posedge clk or reset.
//
//   States: IDLE, RUN, PAUSE, EXPIRED.
//
//   Input priority each cycle: load > pause > start.
//
//   load (any state):
//   - Valid when ld_s_l<=5, ld_s_r<=9, ld_m_l<=5, ld_m_r<=9.
//   - Valid: digits take the preset. State goes to IDLE. Prescaler clears.
//     expired clears.
//   - Invalid: load_err pulses; digits and state are unchanged.
//   - A valid load of 00:00 goes to IDLE, not EXPIRED.
//
//   start:
//   - IDLE or PAUSE with count != 00:00: go to RUN.
//   - IDLE with count == 00:00: ignored.
//   - In RUN or EXPIRED: ignored.
//
//   pause:
//   - RUN: go to PAUSE. Prescaler value is held, not cleared.
//   - Other states: ignored.
//
//   RUN:
//   - Prescaler counts 0..TICK_DIV-1. The tick is the cycle with prescaler == TICK_DIV-1.
//   - On the tick the prescaler wraps to 0 and the count decrements by 1 second.
//   - Borrow chain: Q_R 0->9 and borrow from Q_L; Q_L 0->5 and borrow from M_R;
//     M_R 0->9 and borrow from M_L.
//   - 00:00 is never decremented.
//   - Latency: from IDLE, first decrement occurs TICK_DIV clk edges after the start edge.
//     From PAUSE, the prescaler continues from its held value.
//
//   Expiry:
//   - Happens on the edge where the decrement yields 00:00.
//   - On that edge: digits=0, state=EXPIRED, done=1 for that cycle only, expired=1.
//     running=0 from the next cycle.
//   - EXPIRED is left only by a valid load or by reset.
//
//   Digit ranges: out-of-range digit values are unreachable. The 59:59 max preset
//   counts down fully (3599 ticks).
//
//   Reset mid-count: immediate clear to IDLE/00:00. No done pulse.
//
// TESTING (sim TICK_DIV=4)
//   1. reset low -> all digits 0, running/done/expired/load_err 0; release, idle holds.
//   2. load 00:12, start -> decrements every 4 clk: 00:11 .. 00:10, 00:09 (borrow),
//      00:00 with done one cycle, expired high.
//   3. load 10:00, start -> 09:59 after 4 clk (full borrow chain); pause after 2 more
//      clk holds 09:59 for 20 clk; start -> 09:58 after remaining 2 clk.
//   4. load ld_s_l=6 while counting 05:30 -> load_err 1 cycle, count and RUN unaffected.
//   5. load and pause and start same cycle in RUN -> preset taken, state IDLE,
//      running=0; start at 00:00 in IDLE -> stays IDLE, no done.
//   6. reset asserted mid-RUN at 03:17 -> asynchronously 00:00, IDLE, no done pulse.

Source files
------------

// File: rtl/countdown_timer.sv
// BCD mm:ss countdown timer: loads a preset, decrements once per TICK_DIV clocks
// until 00:00, then holds in EXPIRED until a valid load.
module countdown_timer #(
    parameter int TICK_DIV = 100_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    input  logic [2:0] ld_m_l,
    input  logic [3:0] ld_m_r,
    input  logic [2:0] ld_s_l,
    input  logic [3:0] ld_s_r,
    input  logic       start,
    input  logic       pause,
    output logic [2:0] M_L,
    output logic [3:0] M_R,
    output logic [2:0] Q_L,
    output logic [3:0] Q_R,
    output logic       running,
    output logic       done,
    output logic       expired,
    output logic       load_err
);

    localparam int            PW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] TICK_LAST = PW'(TICK_DIV - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_PAUSE,
        ST_EXPIRED
    } state_t;

    state_t        r_state, w_state_nxt;
    logic [PW-1:0] r_presc, w_presc_nxt;
    logic [2:0]    r_m_l, w_m_l_nxt, w_dec_m_l;
    logic [3:0]    r_m_r, w_m_r_nxt, w_dec_m_r;
    logic [2:0]    r_q_l, w_q_l_nxt, w_dec_q_l;
    logic [3:0]    r_q_r, w_q_r_nxt, w_dec_q_r;
    logic          r_running, r_done, r_expired, r_load_err;
    logic          w_done_nxt, w_load_err_nxt;
    logic          w_ld_valid, w_is_zero, w_dec_zero, w_tick, w_resume;

    assign w_ld_valid = (ld_m_l <= 3'd5) && (ld_m_r <= 4'd9) &&
                        (ld_s_l <= 3'd5) && (ld_s_r <= 4'd9);
    assign w_is_zero  = (r_m_l == 3'd0) && (r_m_r == 4'd0) &&
                        (r_q_l == 3'd0) && (r_q_r == 4'd0);
    assign w_dec_zero = (w_dec_m_l == 3'd0) && (w_dec_m_r == 4'd0) &&
                        (w_dec_q_l == 3'd0) && (w_dec_q_r == 4'd0);
    assign w_tick     = (r_presc == TICK_LAST);
    // pause outranks start, so a simultaneous pause suppresses a resume
    assign w_resume   = start && !pause && !w_is_zero;

    // One-second decrement with the Q_R -> Q_L -> M_R -> M_L borrow chain
    always_comb begin
        w_dec_m_l = r_m_l;
        w_dec_m_r = r_m_r;
        w_dec_q_l = r_q_l;
        w_dec_q_r = r_q_r;
        if (r_q_r != 4'd0) begin
            w_dec_q_r = r_q_r - 4'd1;
        end else begin
            w_dec_q_r = 4'd9;
            if (r_q_l != 3'd0) begin
                w_dec_q_l = r_q_l - 3'd1;
            end else begin
                w_dec_q_l = 3'd5;
                if (r_m_r != 4'd0) begin
                    w_dec_m_r = r_m_r - 4'd1;
                end else begin
                    w_dec_m_r = 4'd9;
                    w_dec_m_l = r_m_l - 3'd1;
                end
            end
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_presc_nxt    = r_presc;
        w_m_l_nxt      = r_m_l;
        w_m_r_nxt      = r_m_r;
        w_q_l_nxt      = r_q_l;
        w_q_r_nxt      = r_q_r;
        w_done_nxt     = 1'b0;
        w_load_err_nxt = 1'b0;

        if (load && w_ld_valid) begin
            w_state_nxt = ST_IDLE;
            w_presc_nxt = '0;
            w_m_l_nxt   = ld_m_l;
            w_m_r_nxt   = ld_m_r;
            w_q_l_nxt   = ld_s_l;
            w_q_r_nxt   = ld_s_r;
        end else begin
            // A rejected load freezes control inputs but lets a running count continue
            w_load_err_nxt = load;
            case (r_state)
                ST_IDLE, ST_PAUSE: begin
                    if (!load && w_resume) w_state_nxt = ST_RUN;
                end
                ST_RUN: begin
                    if (!load && pause) begin
                        w_state_nxt = ST_PAUSE;
                    end else if (w_tick && !w_is_zero) begin
                        w_presc_nxt = '0;
                        w_m_l_nxt   = w_dec_m_l;
                        w_m_r_nxt   = w_dec_m_r;
                        w_q_l_nxt   = w_dec_q_l;
                        w_q_r_nxt   = w_dec_q_r;
                        if (w_dec_zero) begin
                            w_state_nxt = ST_EXPIRED;
                            w_done_nxt  = 1'b1;
                        end
                    end else begin
                        w_presc_nxt = r_presc + 1'b1;
                    end
                end
                ST_EXPIRED: ;
                default: w_state_nxt = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= ST_IDLE;
            r_presc    <= '0;
            r_m_l      <= '0;
            r_m_r      <= '0;
            r_q_l      <= '0;
            r_q_r      <= '0;
            r_running  <= 1'b0;
            r_done     <= 1'b0;
            r_expired  <= 1'b0;
            r_load_err <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_presc    <= w_presc_nxt;
            r_m_l      <= w_m_l_nxt;
            r_m_r      <= w_m_r_nxt;
            r_q_l      <= w_q_l_nxt;
            r_q_r      <= w_q_r_nxt;
            r_running  <= (w_state_nxt == ST_RUN);
            r_done     <= w_done_nxt;
            r_expired  <= (w_state_nxt == ST_EXPIRED);
            r_load_err <= w_load_err_nxt;
        end
    end

    assign M_L      = r_m_l;
    assign M_R      = r_m_r;
    assign Q_L      = r_q_l;
    assign Q_R      = r_q_r;
    assign running  = r_running;
    assign done     = r_done;
    assign expired  = r_expired;
    assign load_err = r_load_err;

endmodule
